cache_line_fill_buffer: RTL and testbench

Line fill buffer that services the instruction/data cache controller's miss requests. On `LB_Enable`, it fetches one full cache line from the memory-side read port in critical-word-first (wrapping) order. It flags the critical word as soon as it arrives, so the controller can release the pipeline stall, and keeps filling the rest of the line in the background. It then presents the assembled line and holds `LB_Completed` until the controller lets go of `LB_Enable`.

---
 rtl/cache_line_fill_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_cache_line_fill_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill_buffer.sv
// Cache line fill buffer: fetches one line from the memory read port in
// critical-word-first (wrapping) order and reports the critical word early.
// The rest of the line keeps filling in the background, and the finished
// line is reported through LB_Completed.
module cache_line_fill_buffer #(
   parameter int WORDS_PER_LINE = 8
) (
   input  logic                           Clk,
   input  logic                           Rst_n,
   input  logic                           LB_Enable,
   input  logic [31:0]                    LineAddress,
   output logic                           LB_FirstWord,
   output logic                           LB_Completed,
   output logic [31:0]                    CrtWordData,
   output logic [32*WORDS_PER_LINE-1:0]   LineData,
   output logic                           M_ReqValid,
   output logic [31:0]                    M_ReqAddr,
   input  logic                           M_ReqReady,
   input  logic                           M_RspValid,
   input  logic [31:0]                    M_RspData
);

   localparam int OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int BASE_W = 30 - OFF_W;
   localparam int LINE_W = 32 * WORDS_PER_LINE;
   localparam logic [OFF_W-1:0] OFF_ONE  = {{(OFF_W-1){1'b0}}, 1'b1};
   localparam logic [OFF_W-1:0] OFF_LAST = {OFF_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic [OFF_W-1:0]    start_q, start_d;
   logic [OFF_W-1:0]    beat_q, beat_d;
   // armed: LB_Enable has been seen low since the last fill started, so a
   // level still held from the previous fill cannot trigger a new one.
   logic                armed_q, armed_d;
   // abort: LB_Enable dropped mid-fill; finish the handshake but never complete.
   logic                abort_q, abort_d;
   logic                req_valid_q, req_valid_d;
   logic [31:0]         req_addr_q, req_addr_d;
   logic                first_word_q, first_word_d;
   logic                completed_q, completed_d;
   logic [31:0]         crt_word_q, crt_word_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [OFF_W-1:0]    idx_s;
   logic [OFF_W-1:0]    idx_next_s;

   // Word index of the current beat and of the following beat (wraps in the line).
   always_comb begin
      idx_s      = start_q + beat_q;
      idx_next_s = idx_s + OFF_ONE;
   end

   // Next-state and registered-output computation for the fill sequencer.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      start_d      = start_q;
      beat_d       = beat_q;
      armed_d      = armed_q;
      abort_d      = abort_q;
      req_valid_d  = 1'b0;
      req_addr_d   = req_addr_q;
      first_word_d = 1'b0;
      completed_d  = 1'b0;
      crt_word_d   = crt_word_q;
      line_d       = line_q;

      if (!LB_Enable) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (LB_Enable && armed_q) begin
               state_d     = ST_REQ;
               base_d      = LineAddress[31:OFF_W+2];
               start_d     = LineAddress[OFF_W+1:2];
               beat_d      = {OFF_W{1'b0}};
               armed_d     = 1'b0;
               abort_d     = 1'b0;
               req_valid_d = 1'b1;
               req_addr_d  = LineAddress & 32'hFFFF_FFFC;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_REQ: begin
            if (!LB_Enable) begin
               abort_d = 1'b1;
            end else begin
               abort_d = abort_q;
            end
            if (M_ReqReady) begin
               state_d     = ST_WAIT_RSP;
               req_valid_d = 1'b0;
            end else begin
               state_d     = ST_REQ;
               req_valid_d = 1'b1;
            end
         end

         ST_WAIT_RSP: begin
            if (!LB_Enable) begin
               abort_d = 1'b1;
            end else begin
               abort_d = abort_q;
            end
            if (M_RspValid) begin
               for (int w = 0; w < WORDS_PER_LINE; w++) begin
                  if (idx_s == w[OFF_W-1:0]) begin
                     line_d[32*w +: 32] = M_RspData;
                  end else begin
                     line_d[32*w +: 32] = line_q[32*w +: 32];
                  end
               end
               if (beat_q == {OFF_W{1'b0}}) begin
                  first_word_d = 1'b1;
                  crt_word_d   = M_RspData;
               end else begin
                  first_word_d = 1'b0;
               end
               if (beat_q == OFF_LAST) begin
                  state_d     = ST_DONE;
                  completed_d = LB_Enable && !abort_d;
               end else begin
                  state_d     = ST_REQ;
                  beat_d      = beat_q + OFF_ONE;
                  req_valid_d = 1'b1;
                  req_addr_d  = {base_q, idx_next_s, 2'b00};
               end
            end else begin
               state_d = ST_WAIT_RSP;
            end
         end

         ST_DONE: begin
            if (LB_Enable && !abort_q) begin
               state_d     = ST_DONE;
               completed_d = 1'b1;
            end else begin
               state_d     = ST_IDLE;
               completed_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; async reset clears everything immediately.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= ST_IDLE;
         base_q       <= {BASE_W{1'b0}};
         start_q      <= {OFF_W{1'b0}};
         beat_q       <= {OFF_W{1'b0}};
         armed_q      <= 1'b1;
         abort_q      <= 1'b0;
         req_valid_q  <= 1'b0;
         req_addr_q   <= 32'h0000_0000;
         first_word_q <= 1'b0;
         completed_q  <= 1'b0;
         crt_word_q   <= 32'h0000_0000;
         line_q       <= {LINE_W{1'b0}};
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         start_q      <= start_d;
         beat_q       <= beat_d;
         armed_q      <= armed_d;
         abort_q      <= abort_d;
         req_valid_q  <= req_valid_d;
         req_addr_q   <= req_addr_d;
         first_word_q <= first_word_d;
         completed_q  <= completed_d;
         crt_word_q   <= crt_word_d;
         line_q       <= line_d;
      end
   end

   assign M_ReqValid   = req_valid_q;
   assign M_ReqAddr    = req_addr_q;
   assign LB_FirstWord = first_word_q;
   assign LB_Completed = completed_q;
   assign CrtWordData  = crt_word_q;
   assign LineData     = line_q;

endmodule

// File: tb/tb_cache_line_fill_buffer.sv
// Directed testbench for cache_line_fill_buffer with a one-outstanding
// memory responder driven cycle by cycle on the falling clock edge.
module tb_cache_line_fill_buffer;

   localparam int WPL = 8;

   logic             Clk = 1'b0;
   logic             Rst_n = 1'b0;
   logic             LB_Enable = 1'b0;
   logic [31:0]      LineAddress = 32'h0;
   logic             LB_FirstWord;
   logic             LB_Completed;
   logic [31:0]      CrtWordData;
   logic [32*WPL-1:0] LineData;
   logic             M_ReqValid;
   logic [31:0]      M_ReqAddr;
   logic             M_ReqReady = 1'b1;
   logic             M_RspValid = 1'b0;
   logic [31:0]      M_RspData = 32'h0;

   cache_line_fill_buffer #(.WORDS_PER_LINE(WPL)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .LB_Enable(LB_Enable), .LineAddress(LineAddress),
      .LB_FirstWord(LB_FirstWord), .LB_Completed(LB_Completed),
      .CrtWordData(CrtWordData), .LineData(LineData),
      .M_ReqValid(M_ReqValid), .M_ReqAddr(M_ReqAddr), .M_ReqReady(M_ReqReady),
      .M_RspValid(M_RspValid), .M_RspData(M_RspData)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp_wrap [8] = '{32'h1014, 32'h1018, 32'h101C, 32'h1000,
                                 32'h1004, 32'h1008, 32'h100C, 32'h1010};

   // run configuration
   int          bp_beat, bp_len, drop_beat, hold_after, rst_beat;
   logic [31:0] data_base;
   // observations of the last run
   logic [31:0] req_log[$];
   logic [31:0] stall_log[$];
   int          fw_cnt, fw_cyc, comp_cyc, comp_cnt, comp_fall, first_valid_cyc, valid_after_comp;
   logic [31:0] crt_at_fw;
   logic        rst_hit, rst_valid, rst_fw, rst_comp;
   logic [31:0] rst_addr, rst_crt;
   logic [32*WPL-1:0] rst_line;

   task automatic set_defaults();
      bp_beat = -1; bp_len = 0; drop_beat = -1; hold_after = 0; rst_beat = -1;
      data_base = 32'hA000_0000;
   endtask

   // Raise LB_Enable with addr, then play the memory side for n_cycles cycles.
   // Cycle 1 is the cycle right after the edge that first samples LB_Enable high.
   task automatic run_fill(input logic [31:0] addr, input int n_cycles);
      int          accepts;
      int          stall;
      bit          acc_pend;
      bit          ready;
      logic [31:0] last_addr;
      accepts = 0; stall = 0; acc_pend = 1'b0; last_addr = 32'h0;
      req_log.delete(); stall_log.delete();
      fw_cnt = 0; fw_cyc = -1; comp_cyc = -1; comp_cnt = 0; comp_fall = -1;
      first_valid_cyc = -1; valid_after_comp = 0; rst_hit = 1'b0; crt_at_fw = 32'h0;
      @(negedge Clk);
      LB_Enable = 1'b1; LineAddress = addr; M_ReqReady = 1'b1; M_RspValid = 1'b0;
      for (int cyc = 1; cyc <= n_cycles; cyc++) begin
         @(negedge Clk);
         if (rst_beat >= 0 && acc_pend && accepts == rst_beat + 1) begin
            Rst_n = 1'b0; LB_Enable = 1'b0; M_RspValid = 1'b0;
            #1;
            rst_valid = M_ReqValid; rst_fw = LB_FirstWord; rst_comp = LB_Completed;
            rst_addr = M_ReqAddr; rst_crt = CrtWordData; rst_line = LineData;
            rst_hit = 1'b1;
            break;
         end
         M_RspValid = acc_pend;
         M_RspData  = acc_pend ? (data_base + {29'd0, last_addr[4:2]}) : 32'h0;
         acc_pend   = 1'b0;
         if (LB_FirstWord) begin
            fw_cnt++; fw_cyc = cyc; crt_at_fw = CrtWordData;
         end
         if (LB_Completed) begin
            comp_cnt++;
            if (comp_cyc < 0) comp_cyc = cyc;
         end else if (comp_cyc >= 0 && comp_fall < 0) begin
            comp_fall = cyc;
         end
         if (M_ReqValid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (M_ReqValid && comp_cyc >= 0) valid_after_comp++;
         if (drop_beat >= 0 && M_ReqValid && accepts == drop_beat) LB_Enable = 1'b0;
         if (comp_cyc >= 0 && cyc == comp_cyc + hold_after) LB_Enable = 1'b0;
         if (M_ReqValid) begin
            ready = !(accepts == bp_beat && stall < bp_len);
            if (!ready) begin
               stall++;
               stall_log.push_back(M_ReqAddr);
            end else begin
               req_log.push_back(M_ReqAddr);
               last_addr = M_ReqAddr;
               acc_pend  = 1'b1;
               accepts++;
            end
            M_ReqReady = ready;
         end else begin
            M_ReqReady = 1'b1;
         end
      end
      @(negedge Clk);
      M_RspValid = 1'b0; LB_Enable = 1'b0; M_ReqReady = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge Clk);
      n_cmp++; if (M_ReqValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", M_ReqValid); end
      n_cmp++; if (LB_FirstWord !== 1'b0) begin n_bad++; $display("FAIL rst_firstword: got %b expected 0", LB_FirstWord); end
      n_cmp++; if (LB_Completed !== 1'b0) begin n_bad++; $display("FAIL rst_completed: got %b expected 0", LB_Completed); end
      n_cmp++; if (M_ReqAddr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h expected 0", M_ReqAddr); end
      n_cmp++; if (CrtWordData !== 32'h0) begin n_bad++; $display("FAIL rst_crt: got %h expected 0", CrtWordData); end
      n_cmp++; if (LineData !== '0) begin n_bad++; $display("FAIL rst_line: got %h expected 0", LineData); end
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
      n_cmp++; if (M_ReqValid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b expected 0", M_ReqValid); end
   endtask

   task automatic test_wrap_order();
      logic [31:0] got;
      set_defaults();
      run_fill(32'h0000_1014, 24);
      n_cmp++; if (req_log.size() !== 8) begin n_bad++; $display("FAIL wrap_count: got %0d expected 8", req_log.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD;
         n_cmp++; if (got !== exp_wrap[i]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, got, exp_wrap[i]); end
      end
      n_cmp++; if (first_valid_cyc !== 1) begin n_bad++; $display("FAIL req_latency: got %0d expected 1", first_valid_cyc); end
      n_cmp++; if (fw_cyc !== 3) begin n_bad++; $display("FAIL firstword_cycle: got %0d expected 3", fw_cyc); end
      n_cmp++; if (fw_cnt !== 1) begin n_bad++; $display("FAIL firstword_pulses: got %0d expected 1", fw_cnt); end
      n_cmp++; if (crt_at_fw !== 32'hA000_0005) begin n_bad++; $display("FAIL crt_word: got %h expected a0000005", crt_at_fw); end
      n_cmp++; if (comp_cyc !== 17) begin n_bad++; $display("FAIL completed_cycle: got %0d expected 17", comp_cyc); end
      n_cmp++; if (comp_fall !== 18) begin n_bad++; $display("FAIL completed_fall: got %0d expected 18", comp_fall); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (LineData[32*i +: 32] !== 32'hA000_0000 + i) begin
            n_bad++; $display("FAIL line_word[%0d]: got %h expected %h", i, LineData[32*i +: 32], 32'hA000_0000 + i);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] got;
      set_defaults();
      bp_beat = 2; bp_len = 3;
      run_fill(32'h0000_1014, 28);
      n_cmp++; if (stall_log.size() !== 3) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_log.size()); end
      for (int i = 0; i < stall_log.size(); i++) begin
         n_cmp++; if (stall_log[i] !== 32'h101C) begin n_bad++; $display("FAIL bp_hold_addr[%0d]: got %h expected 0000101c", i, stall_log[i]); end
      end
      for (int i = 0; i < 8; i++) begin
         got = (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD;
         n_cmp++; if (got !== exp_wrap[i]) begin n_bad++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, got, exp_wrap[i]); end
      end
      n_cmp++; if (comp_cyc !== 20) begin n_bad++; $display("FAIL bp_completed_cycle: got %0d expected 20", comp_cyc); end
   endtask

   task automatic test_release();
      set_defaults();
      hold_after = 4;
      run_fill(32'h0000_1014, 30);
      n_cmp++; if (comp_cyc !== 17) begin n_bad++; $display("FAIL rel_completed_cycle: got %0d expected 17", comp_cyc); end
      n_cmp++; if (comp_cnt !== 5) begin n_bad++; $display("FAIL rel_completed_len: got %0d expected 5", comp_cnt); end
      n_cmp++; if (comp_fall !== 22) begin n_bad++; $display("FAIL rel_completed_fall: got %0d expected 22", comp_fall); end
      n_cmp++; if (valid_after_comp !== 0) begin n_bad++; $display("FAIL rel_no_refill: got %0d expected 0", valid_after_comp); end
      n_cmp++; if (req_log.size() !== 8) begin n_bad++; $display("FAIL rel_req_count: got %0d expected 8", req_log.size()); end
   endtask

   task automatic test_enable_drop();
      set_defaults();
      data_base = 32'hC000_0000;
      drop_beat = 3;
      run_fill(32'h0000_1014, 26);
      n_cmp++; if (req_log.size() !== 8) begin n_bad++; $display("FAIL drop_req_count: got %0d expected 8", req_log.size()); end
      n_cmp++; if (comp_cnt !== 0) begin n_bad++; $display("FAIL drop_completed: got %0d expected 0", comp_cnt); end
      n_cmp++; if (fw_cnt !== 1) begin n_bad++; $display("FAIL drop_firstword: got %0d expected 1", fw_cnt); end
      n_cmp++; if (LineData[32*7 +: 32] !== 32'hC000_0007) begin n_bad++; $display("FAIL drop_line_word7: got %h expected c0000007", LineData[32*7 +: 32]); end
      n_cmp++; if (M_ReqValid !== 1'b0) begin n_bad++; $display("FAIL drop_idle_valid: got %b expected 0", M_ReqValid); end
      set_defaults();
      run_fill(32'h0000_1014, 20);
      n_cmp++; if (comp_cyc !== 17) begin n_bad++; $display("FAIL drop_refill_completed: got %0d expected 17", comp_cyc); end
   endtask

   task automatic test_async_reset();
      logic [31:0] got;
      set_defaults();
      rst_beat = 4;
      run_fill(32'h0000_1014, 20);
      n_cmp++; if (rst_hit !== 1'b1) begin n_bad++; $display("FAIL ar_reached_beat4: got %b expected 1", rst_hit); end
      n_cmp++; if (rst_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b expected 0", rst_valid); end
      n_cmp++; if (rst_fw !== 1'b0 || rst_comp !== 1'b0) begin n_bad++; $display("FAIL ar_flags: got %b%b expected 00", rst_fw, rst_comp); end
      n_cmp++; if (rst_addr !== 32'h0) begin n_bad++; $display("FAIL ar_addr: got %h expected 0", rst_addr); end
      n_cmp++; if (rst_crt !== 32'h0) begin n_bad++; $display("FAIL ar_crt: got %h expected 0", rst_crt); end
      n_cmp++; if (rst_line !== '0) begin n_bad++; $display("FAIL ar_line: got %h expected 0", rst_line); end
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
      set_defaults();
      data_base = 32'hB000_0000;
      run_fill(32'h0000_2000, 24);
      for (int i = 0; i < 8; i++) begin
         got = (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD;
         n_cmp++; if (got !== 32'h2000 + 4*i) begin n_bad++; $display("FAIL ar_addr[%0d]: got %h expected %h", i, got, 32'h2000 + 4*i); end
      end
      n_cmp++; if (crt_at_fw !== 32'hB000_0000) begin n_bad++; $display("FAIL ar_crt_word: got %h expected b0000000", crt_at_fw); end
      n_cmp++; if (comp_cyc !== 17) begin n_bad++; $display("FAIL ar_completed_cycle: got %0d expected 17", comp_cyc); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (LineData[32*i +: 32] !== 32'hB000_0000 + i) begin
            n_bad++; $display("FAIL ar_line_word[%0d]: got %h expected %h", i, LineData[32*i +: 32], 32'hB000_0000 + i);
         end
      end
   endtask

   initial begin
      set_defaults();
      test_reset();
      test_wrap_order();
      test_backpressure();
      test_release();
      test_enable_drop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
